// File: rtl/hashout_checker.sv
// hashout_checker: drains heavyhash results from the hashout FIFO,
// tags each with its nonce, compares against target and queues hits.
module hashout_checker #(
  parameter int HIT_DEPTH = 4,
  parameter int LEN_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      target,
  input  logic [31:0]      nonce_base,
  input  logic [LEN_W-1:0] job_len,
  input  logic             hashout_empty,
  input  logic [63:0]      hashout_dout,
  output logic             hashout_re,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [31:0]      hit_nonce,
  output logic [63:0]      hit_hash,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] processed_cnt
);

  localparam int AW = $clog2(HIT_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  typedef struct packed {
    logic [31:0] nonce;
    logic [63:0] hash;
  } hit_t;

  state_t           state_q;
  state_t           state_d;
  logic [63:0]      tgt_q;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_cnt;
  logic             rd_pend;

  hit_t             mem [HIT_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      q_count;

  logic             accept;
  logic             push;
  logic             pop;
  logic             room;
  logic [31:0]      cur_nonce;

  assign accept    = (state_q == S_IDLE) && start;
  assign cur_nonce = base_q + 32'(processed_cnt);
  assign push      = rd_pend && (hashout_dout <= tgt_q);
  assign hit_valid = (q_count != '0);
  assign pop       = hit_valid && hit_ready;
  assign hit_nonce = mem[rd_ptr].nonce;
  assign hit_hash  = mem[rd_ptr].hash;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

  // An in-flight read reserves a queue slot so a push never overflows.
  assign room = (CW'(q_count) + CW'(rd_pend)) < CW'(HIT_DEPTH);

  assign hashout_re = (state_q == S_RUN) && !hashout_empty &&
                      (rd_cnt < len_q) && room;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (job_len == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if ((rd_cnt == len_q) && !rd_pend) begin
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      tgt_q         <= '0;
      base_q        <= '0;
      len_q         <= '0;
      rd_cnt        <= '0;
      rd_pend       <= 1'b0;
      processed_cnt <= '0;
    end else begin
      state_q <= state_d;
      rd_pend <= hashout_re;
      if (accept) begin
        tgt_q         <= target;
        base_q        <= nonce_base;
        len_q         <= job_len;
        rd_cnt        <= '0;
        processed_cnt <= '0;
      end else begin
        if (hashout_re) begin
          rd_cnt <= rd_cnt + LEN_W'(1);
        end
        if (rd_pend) begin
          processed_cnt <= processed_cnt + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      for (int i = 0; i < HIT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{nonce: cur_nonce, hash: hashout_dout};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        push && !pop: q_count <= q_count + (AW+1)'(1);
        pop && !push: q_count <= q_count - (AW+1)'(1);
        default:      q_count <= q_count;
      endcase
    end
  end

endmodule

// File: tb/tb_hashout_checker.sv
// tb_hashout_checker: FIFO model plus hit scoreboard for
// hashout_checker.
module tb_hashout_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] target = '0;
  logic [31:0] nonce_base = '0;
  logic [31:0] job_len = '0;
  logic        hashout_empty = 1'b1;
  logic [63:0] hashout_dout = '0;
  logic        hashout_re;
  logic        hit_valid;
  logic        hit_ready = 1'b0;
  logic [31:0] hit_nonce;
  logic [63:0] hit_hash;
  logic        busy;
  logic        done;
  logic [31:0] processed_cnt;

  hashout_checker #(
    .HIT_DEPTH(4),
    .LEN_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .target(target),
    .nonce_base(nonce_base),
    .job_len(job_len),
    .hashout_empty(hashout_empty),
    .hashout_dout(hashout_dout),
    .hashout_re(hashout_re),
    .hit_valid(hit_valid),
    .hit_ready(hit_ready),
    .hit_nonce(hit_nonce),
    .hit_hash(hit_hash),
    .busy(busy),
    .done(done),
    .processed_cnt(processed_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] fifo_q [$];
  logic [95:0] exp_q [$];
  bit stall = 1'b0;
  int re_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  bit prev_stall = 1'b0;
  logic [95:0] prev_head = '0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Standard (non-FWFT) FIFO: data one cycle after re.
  always @(posedge clk) begin
    if (hashout_re) begin
      if (fifo_q.size() > 0) hashout_dout <= fifo_q.pop_front();
      else check("re_on_empty", 96'(1), 96'(0));
    end
    hashout_empty <= stall || (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      if (hashout_re) re_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (prev_stall)
        check("hit_stable", {hit_nonce, hit_hash}, prev_head);
      prev_stall = hit_valid && !hit_ready;
      prev_head = {hit_nonce, hit_hash};
      if (hit_valid && hit_ready) begin
        if (exp_q.size() == 0) check("hit_extra", 96'(1), 96'(0));
        else check("hit", {hit_nonce, hit_hash}, exp_q.pop_front());
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] h, input logic [63:0] tgt,
                      input logic [31:0] nonce);
    fifo_q.push_back(h);
    if (h <= tgt) exp_q.push_back({nonce, h});
  endtask

  task automatic go(input logic [63:0] tgt, input logic [31:0] base,
                    input logic [31:0] len);
    target = tgt;
    nonce_base = base;
    job_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 96'(seen), 96'(1));
  endtask

  task automatic wait_drain(input int max, input string tag);
    for (int i = 0; i < max && exp_q.size() > 0; i++) tick();
    check(tag, 96'(exp_q.size()), 96'(0));
    tick();
    check({tag, "_valid"}, 96'(hit_valid), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [63:0] t1 [4];
    logic [31:0] b;
    t1[0] = 64'h1;
    t1[1] = ONES;
    t1[2] = 64'h8000_0000_0000_0000;
    t1[3] = 64'h7;

    repeat (3) tick();
    check("rst_valid", 96'(hit_valid), 96'(0));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_done", 96'(done), 96'(0));
    check("rst_re", 96'(hashout_re), 96'(0));
    check("rst_cnt", 96'(processed_cnt), 96'(0));
    check("rst_hash", 96'(hit_hash), 96'(0));
    rst = 1'b1;
    tick();

    // Mixed hits/misses against a mid-range target.
    hit_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      load(t1[i], 64'h8000_0000_0000_0000, 32'h10 + 32'(i));
    go(64'h8000_0000_0000_0000, 32'h10, 32'd4);
    wait_done(50, "t1_done");
    check("t1_cnt", 96'(processed_cnt), 96'(4));
    tick();
    check("t1_pulse", 96'(done), 96'(0));
    check("t1_idle", 96'(busy), 96'(0));
    wait_drain(20, "t1_drain");

    // Backpressure: queue fills, reads stop until drained.
    hit_ready = 1'b0;
    re_cnt = 0;
    for (int i = 0; i < 8; i++)
      load(64'h1000 + 64'(i), ONES, 32'h100 + 32'(i));
    go(ONES, 32'h100, 32'd8);
    repeat (20) tick();
    check("t2_reads", 96'(re_cnt), 96'(4));
    check("t2_re_low", 96'(hashout_re), 96'(0));
    check("t2_busy", 96'(busy), 96'(1));
    hit_ready = 1'b1;
    wait_done(60, "t2_done");
    check("t2_reads_all", 96'(re_cnt), 96'(8));
    wait_drain(20, "t2_drain");

    // Nonce wraps past 2^32-1.
    load(64'hAA, ONES, 32'hFFFF_FFFE);
    load(64'hBB, ONES, 32'hFFFF_FFFF);
    load(64'hCC, ONES, 32'h0000_0000);
    go(ONES, 32'hFFFF_FFFE, 32'd3);
    wait_done(40, "t3_done");
    check("t3_cnt", 96'(processed_cnt), 96'(3));
    wait_drain(20, "t3_drain");

    // Zero-length job.
    re_cnt = 0;
    busy_cnt = 0;
    done_cnt = 0;
    go(ONES, 32'h55, 32'd0);
    wait_done(10, "t4_done");
    repeat (3) tick();
    check("t4_busy_cyc", 96'(busy_cnt), 96'(1));
    check("t4_done_cnt", 96'(done_cnt), 96'(1));
    check("t4_reads", 96'(re_cnt), 96'(0));
    check("t4_cnt", 96'(processed_cnt), 96'(0));

    // Upstream stall with a stray start mid-job.
    b = 32'h200;
    load(64'h50, 64'h100, b);
    load(64'h200, 64'h100, b + 32'd1);
    go(64'h100, b, 32'd4);
    repeat (6) tick();
    stall = 1'b1;
    re_cnt = 0;
    repeat (10) tick();
    target = 64'h0;
    nonce_base = 32'h999;
    job_len = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("t5_no_reads", 96'(re_cnt), 96'(0));
    check("t5_busy", 96'(busy), 96'(1));
    check("t5_cnt_mid", 96'(processed_cnt), 96'(2));
    load(64'h100, 64'h100, b + 32'd2);
    load(64'h0, 64'h100, b + 32'd3);
    stall = 1'b0;
    wait_done(40, "t5_done");
    check("t5_cnt", 96'(processed_cnt), 96'(4));
    wait_drain(20, "t5_drain");

    // Asynchronous reset with hits queued.
    hit_ready = 1'b0;
    load(64'h11, ONES, 32'h300);
    load(64'h22, ONES, 32'h301);
    go(ONES, 32'h300, 32'd8);
    repeat (8) tick();
    check("t6_queued", 96'(hit_valid), 96'(1));
    rst = 1'b0;
    #1;
    check("t6_valid", 96'(hit_valid), 96'(0));
    check("t6_busy", 96'(busy), 96'(0));
    check("t6_re", 96'(hashout_re), 96'(0));
    fifo_q.delete();
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    hit_ready = 1'b1;
    load(64'h5, 64'h1000, 32'h40);
    load(64'h2000, 64'h1000, 32'h41);
    load(64'h1000, 64'h1000, 32'h42);
    go(64'h1000, 32'h40, 32'd3);
    wait_done(40, "t6_done");
    check("t6_cnt", 96'(processed_cnt), 96'(3));
    wait_drain(20, "t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hashout_checker.md
Name: hashout_checker

Overview:
- Consumer (reader) end of the hashout FIFO that the heavyhash matrix engine writes.
- Pops 64-bit heavyhash results and tags each with its nonce (nonce_base + result index). Compares each result against a 64-bit target and queues hits in a small internal buffer for the host/shell to drain over a valid/ready handshake.
- Tracks the job length and signals done once every expected result has been checked.

Parameters:
- HIT_DEPTH, 4, entries in the internal hit queue (power of 2, min 2).
- LEN_W, 32, width of job_len and of processed_cnt.

Ports:
- clk  in  1  global clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  1-cycle pulse; latches target, nonce_base, job_len; ignored unless IDLE
- target  in  64  unsigned threshold; a hit is hash <= target
- nonce_base  in  32  nonce of the first result in the job
- job_len  in  LEN_W  number of results expected for the job
- hashout_empty  in  1  empty flag of the hashout FIFO
- hashout_dout  in  64  FIFO read data, valid the cycle after hashout_re (standard, non-FWFT)
- hashout_re  out  1  FIFO read enable
- hit_valid  out  1  head of hit queue valid
- hit_ready  in  1  consumer accepts the head entry
- hit_nonce  out  32  nonce of head entry
- hit_hash  out  64  hash of head entry
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  1-cycle pulse at job completion
- processed_cnt  out  LEN_W  results compared in the current/last job

Behaviour:
- Reset values (async, rst low): all outputs 0; state IDLE; hit queue empty; counters 0.
- FSM states:
  - IDLE: on start, latch inputs, clear processed_cnt and internal read count rd_cnt, go to RUN.
  - RUN: pops results. When rd_cnt == job_len and no read is in flight, go to FIN. If job_len == 0, go directly to FIN the cycle after start.
  - FIN: done = 1 for exactly one cycle, then IDLE.
  - busy = 1 in RUN and FIN.
- Read rule (RUN only):
  - hashout_re = !hashout_empty && (rd_cnt < job_len) && (q_count + rd_pend < HIT_DEPTH).
  - rd_pend is the registered copy of hashout_re, i.e. one read in flight at most.
  - rd_cnt increments on each hashout_re.
- Compare stage (cycle after hashout_re):
  - Sample hashout_dout; nonce = nonce_base + processed_cnt (mod 2^32, wraps silently); processed_cnt increments.
  - If hashout_dout <= target (64-bit unsigned), push {nonce, hash} into the hit queue at the same clock edge.
  - Total latency from hashout_re to hit_valid is 2 cycles when the queue was empty.
- Hit queue:
  - FIFO of depth HIT_DEPTH. The head drives hit_valid/hit_nonce/hit_hash.
  - Pop on hit_valid && hit_ready.
  - Simultaneous push and pop in one cycle: q_count unchanged, order preserved.
  - The read rule guarantees there is never a push into a full queue.
  - hit_nonce/hit_hash stay stable while hit_valid && !hit_ready.
- Draining:
  - done does not wait for the hit queue to drain; hits stay valid into IDLE and across the next job.
  - The next job's reads stall while the queue is full.
- Boundaries:
  - start while busy: ignored, latched values unchanged.
  - hashout_empty high in RUN: re = 0, state held, no timeout.
  - target = 2^64-1: every result hits. target = 0: only hash == 0 hits.
  - Reset mid-job: queue flushed, in-flight read discarded (FIFO data lost; the upstream FIFO must be reset together).
- processed_cnt holds its final value after done until the next accepted start.

Test Plan:
- job_len=4, nonce_base=0x10, target=0x8000_0000_0000_0000, FIFO holds {0x1, 0xFFFF_FFFF_FFFF_FFFF, 0x8000_0000_0000_0000, 0x7}, hit_ready=1 -> hits (0x10,0x1), (0x12,0x8000…0), (0x13,0x7); done after the 4th compare; processed_cnt=4.
- HIT_DEPTH=4, target=all-ones, job_len=8, hit_ready=0 -> exactly 4 reads, hashout_re then held 0. Raise hit_ready -> remaining 4 read; nonces consecutive and in order.
- nonce_base=0xFFFF_FFFE, job_len=3, target=all-ones -> hit nonces 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- job_len=0 start -> busy 1 cycle, done pulse, no hashout_re, processed_cnt=0.
- FIFO empty for 20 cycles mid-job, with a second start pulse during the stall -> no reads and start ignored; job resumes when data appears with the original target and base.
- rst low during RUN with 2 queued hits -> hit_valid=0, busy=0, hashout_re=0 immediately (asynchronous). After release, a new job runs normally.
